multdiv_ctrl: RTL

Sequencing controller for the iterative multiply/divide unit of the processor. Accepts single-cycle ctrl_MULT / ctrl_DIV start pulses and drives the datapath's init and step strobes. Counts iterations and raises a one-cycle data_resultRDY pulse on completion, with divide-by-zero exception flagging. Sits between the pipeline stall logic and the shared shift/add datapath.

---
 rtl/multdiv_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the iterative multiply/divide unit.
//
// A ctrl_MULT / ctrl_DIV pulse (re)starts an operation in any state. The
// controller strobes dp_step for N cycles (N = MULT_CYCLES or DIV_CYCLES,
// chosen by the registered op select), then raises data_resultRDY for exactly
// one cycle. On that same cycle, data_exception flags a divide by zero.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   ctrl_MULT, ctrl_DIV   one-cycle start pulses (multiply wins if both)
//   divisor_zero          divisor operand is zero, sampled on a start edge
//   dp_init               combinational ctrl_MULT | ctrl_DIV (operand load)
//   dp_op                 registered op select, 0 = multiply, 1 = divide
//   dp_step               datapath iterates this cycle
//   step_count            0-based iteration index
//   busy                  high while running
//   data_resultRDY        one-cycle completion pulse
//   data_exception        divide-by-zero flag, valid with data_resultRDY
//
// Optional feature (macro MULTDIV_DIV0_FAST_EN): when this macro is defined,
// a divide by zero skips the step phase entirely. It reports completion and
// the exception in the first cycle after the start edge.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  output logic             dp_init,
  output logic             dp_op,
  output logic             dp_step,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic   start, start_div, div0, last;

  assign start     = ctrl_MULT | ctrl_DIV;
  // When both pulses arrive together, the multiply takes priority.
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign dp_init   = start;
  assign last      = (step_count == (dp_op ? DIV_LAST : MULT_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dp_step        = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      RUN: begin
        dp_step = 1'b1;
        busy    = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        data_exception = div0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A start pulse aborts whatever is in flight, in every state.
    if (start) begin
      state_nxt = RUN;
`ifdef MULTDIV_DIV0_FAST_EN
      if (start_div && divisor_zero) state_nxt = DONE;
`endif
    end
  end

  // The counter holds at N-1 through DONE and clears on the way back to IDLE.
  // So it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_count <= '0;
      dp_op      <= 1'b0;
      div0       <= 1'b0;
    end else if (start) begin
      step_count <= '0;
      dp_op      <= start_div;
      div0       <= start_div & divisor_zero;
    end else if (state == RUN) begin
      if (!last) step_count <= step_count + 1'b1;
    end else begin
      step_count <= '0;
    end
  end

endmodule
